// File: rtl/calc_pkg.sv
// Shared types for the calculator front-end: per-button debouncer state encoding.
package calc_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/button_debounce_ch.sv
// One push-button channel: 2-FF synchroniser, stability counter and level/pulse FSM.
// The release pulse port is named rel because 'release' is a reserved word.
module button_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  import calc_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p1;
  logic             sync_p2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Stage p1/p2: metastability guard, only sync_p2 is seen by the FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p1 <= raw;
      sync_p2 <= sync_p1;
    end
  end

  // Stage FSM: a change is accepted only after CNT_LAST+1 further stable samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= DB_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        DB_IDLE: begin
          if (sync_p2) begin
            state <= DB_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!sync_p2) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (!sync_p2) begin
            state <= DB_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          if (sync_p2) begin
            state <= DB_PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN independent raw push-buttons into clean levels and press/release pulses.
module button_debouncer #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar k = 0; k < NUM_BTN; k++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (btn_raw[k]),
      .level  (btn_level[k]),
      .press  (btn_press[k]),
      .rel    (btn_release[k])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a run-length reference model queues expected outputs per clock.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  button_debouncer #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rls;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  int prs_cnt0 = 0, rls_cnt0 = 0, prs_cnt1 = 0, rls_cnt1 = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: sync delay of two samples, then a run of D+1 samples that
  // disagree with the current level flips it; any agreeing sample restarts the run.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int           m_run[N];

  task automatic model_step(input logic rn, input logic [N-1:0] raw,
                            output logic [N-1:0] prs, output logic [N-1:0] rls);
    prs = '0;
    rls = '0;
    if (!rn) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int k = 0; k < N; k++) m_run[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = m_s2[k];
            prs[k]   = m_s2[k];
            rls[k]   = !m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic drive(input logic rn, input logic [N-1:0] raw);
    exp_t e;
    logic [N-1:0] p, r;
    reset_n = rn;
    btn_raw = raw;
    model_step(rn, raw, p, r);
    e.cyc = cyc + 1;
    e.lvl = m_lvl;
    e.prs = p;
    e.rls = r;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic rn, input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) drive(rn, raw);
  endtask

  task automatic drive_seq0(input logic [6:0] seq);
    for (int i = 6; i >= 0; i--) drive(1'b1, {1'b0, seq[i]});
  endtask

  task automatic expect_pulses(input string tag, input int p0, input int r0, input int p1, input int r1);
    @(negedge clk);
    #1;
    check_val({tag, "_press0"}, prs_cnt0, p0);
    check_val({tag, "_rel0"}, rls_cnt0, r0);
    check_val({tag, "_press1"}, prs_cnt1, p1);
    check_val({tag, "_rel1"}, rls_cnt1, r1);
    prs_cnt0 = 0;
    rls_cnt0 = 0;
    prs_cnt1 = 0;
    rls_cnt1 = 0;
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      check_val("level", btn_level, mon_e.lvl);
      check_val("press", btn_press, mon_e.prs);
      check_val("release", btn_release, mon_e.rls);
    end
    if (btn_press[0] === 1'b1) prs_cnt0++;
    if (btn_release[0] === 1'b1) rls_cnt0++;
    if (btn_press[1] === 1'b1) prs_cnt1++;
    if (btn_release[1] === 1'b1) rls_cnt1++;
  end

  initial begin
    logic [N-1:0] rnd_raw;
    logic         rnd_rn;
    reset_n = 1'b0;
    btn_raw = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;

    // Buttons held through reset count as a fresh press once reset lifts
    hold(1'b0, 2'b11, 3);
    hold(1'b1, 2'b11, 10);
    expect_pulses("t1_held", 1, 0, 1, 0);
    hold(1'b1, 2'b00, 10);
    expect_pulses("t1_rel", 0, 1, 0, 1);

    // Clean press and release on channel 0
    hold(1'b1, 2'b01, 10);
    expect_pulses("t2_press", 1, 0, 0, 0);
    hold(1'b1, 2'b00, 10);
    expect_pulses("t4_rel", 0, 1, 0, 0);

    // Bounce while idle, then while pressed
    drive_seq0(7'b1110110);
    hold(1'b1, 2'b00, 8);
    expect_pulses("t3_idle_bounce", 0, 0, 0, 0);
    hold(1'b1, 2'b01, 10);
    expect_pulses("t3_press", 1, 0, 0, 0);
    drive_seq0(7'b0001001);
    hold(1'b1, 2'b01, 8);
    expect_pulses("t3_held_bounce", 0, 0, 0, 0);
    hold(1'b1, 2'b00, 10);
    expect_pulses("t3_rel", 0, 1, 0, 0);

    // Reset while waiting out a release discards it silently
    hold(1'b1, 2'b01, 10);
    expect_pulses("t5_press", 1, 0, 0, 0);
    hold(1'b1, 2'b00, 4);
    drive(1'b0, 2'b00);
    hold(1'b1, 2'b00, 10);
    expect_pulses("t5_reset", 0, 0, 0, 0);

    // Staggered presses on both channels
    hold(1'b1, 2'b01, 2);
    hold(1'b1, 2'b11, 10);
    expect_pulses("t6_press", 1, 0, 1, 0);
    hold(1'b1, 2'b00, 10);
    expect_pulses("t6_rel", 0, 1, 0, 1);

    // Random bouncy traffic with occasional resets
    rnd_raw = '0;
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) rnd_raw[k] = ~rnd_raw[k];
      rnd_rn = ($urandom_range(0, 39) != 0);
      drive(rnd_rn, rnd_raw);
    end
    hold(1'b1, 2'b00, 10);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    check_val("drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
